// File: rtl/nor_reduce_pipe.sv
// Pipelined, handshaked wide reduction gate (OR/AND/XOR with optional final inversion).
// Each tree level of FANIN-input nodes is registered; a global stall freezes every stage.
module nor_reduce_pipe #(
  parameter int WIDTH = 10,
  parameter int FANIN = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       MODE,
  input  logic             VI,
  output logic             RI,
  output logic             ZN0,
  output logic             VO,
  input  logic             RO
);

  function automatic int calc_levels(input int w, input int f);
    int l;
    int p;
    l = 1;
    p = f;
    for (int i = 0; i < 8; i++) begin
      if (p < w) begin
        p = p * f;
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Number of partial results held at tree level k (level 0 is the input vector).
  function automatic int lvl_width(input int w, input int f, input int k);
    int p;
    p = 1;
    for (int i = 0; i < 9; i++) begin
      if (i < k) p = p * f;
    end
    return (w + p - 1) / p;
  endfunction

  function automatic int lvl_off(input int w, input int f, input int k);
    int s;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < k) s = s + lvl_width(w, f, i);
    end
    return s;
  endfunction

  function automatic logic red_op(input logic [1:0] op, input logic [FANIN-1:0] g);
    case (op)
      2'b01:   return &g;
      2'b10:   return ^g;
      default: return |g;
    endcase
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, FANIN);
  localparam int TOTAL  = lvl_off(WIDTH, FANIN, LEVELS + 1);

  // All levels packed back to back: level 0 is A, the last level is the single result bit.
  logic [TOTAL-1:0]    dat;
  logic [LEVELS:0]     vld;
  logic [3*LEVELS-1:0] mode_bus;

  assign dat[WIDTH-1:0] = A;
  assign vld[0]         = VI;
  assign mode_bus[2:0]  = MODE;

  assign RI  = !VO || RO;
  assign VO  = vld[LEVELS];
  assign ZN0 = dat[TOTAL-1];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NP      = lvl_width(WIDTH, FANIN, k - 1);
    localparam int NK      = lvl_width(WIDTH, FANIN, k);
    localparam int SRC_OFF = lvl_off(WIDTH, FANIN, k - 1);
    localparam int DST_OFF = lvl_off(WIDTH, FANIN, k);

    logic [2:0]    m;
    logic [NK-1:0] nxt;
    logic [NK-1:0] d_q;
    logic          v_q;

    assign m = mode_bus[3*(k-1) +: 3];

    for (genvar j = 0; j < NK; j++) begin : g_node
      logic [FANIN-1:0] grp;
      for (genvar i = 0; i < FANIN; i++) begin : g_in
        if (j * FANIN + i < NP) begin : g_src
          assign grp[i] = dat[SRC_OFF + j*FANIN + i];
        end else begin : g_pad
          // identity of the selected op so the short last group is neutral
          assign grp[i] = (m[1:0] == 2'b01);
        end
      end
      if (k == LEVELS) begin : g_last
        assign nxt[j] = m[2] ^ red_op(m[1:0], grp);
      end else begin : g_mid
        assign nxt[j] = red_op(m[1:0], grp);
      end
    end

    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        d_q <= '0;
        v_q <= 1'b0;
      end else if (RI) begin
        d_q <= nxt;
        v_q <= vld[k-1];
      end
    end

    assign dat[DST_OFF +: NK] = d_q;
    assign vld[k]             = v_q;

    if (k < LEVELS) begin : g_mode
      logic [2:0] m_q;
      always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
          m_q <= 3'b000;
        end else if (RI) begin
          m_q <= m;
        end
      end
      assign mode_bus[3*k +: 3] = m_q;
    end
  end

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Directed and randomized bench for nor_reduce_pipe: four instances (10/4, 1/4, 16/4, 17/2)
// with a scoreboard fed on input transfers and drained on output transfers.
module tb_nor_reduce_pipe;

  typedef struct packed {
    logic z;
    int   cyc;
  } exp_t;

  localparam int WS [4] = '{10, 1, 16, 17};
  localparam int LS [4] = '{2, 1, 2, 5};

  logic        CK;
  logic        RN;
  logic [9:0]  a0;
  logic [0:0]  a1;
  logic [15:0] a2;
  logic [16:0] a3;
  logic [2:0]  mode [4];
  logic [3:0]  vi;
  logic [3:0]  ro;
  wire  [3:0]  ri;
  wire  [3:0]  vo;
  wire  [3:0]  zn;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic lat_chk = 1'b0;
  exp_t q [4][$];

  nor_reduce_pipe #(.WIDTH(10), .FANIN(4)) dut0 (
    .CK(CK), .RN(RN), .A(a0), .MODE(mode[0]), .VI(vi[0]),
    .RI(ri[0]), .ZN0(zn[0]), .VO(vo[0]), .RO(ro[0]));
  nor_reduce_pipe #(.WIDTH(1), .FANIN(4)) dut1 (
    .CK(CK), .RN(RN), .A(a1), .MODE(mode[1]), .VI(vi[1]),
    .RI(ri[1]), .ZN0(zn[1]), .VO(vo[1]), .RO(ro[1]));
  nor_reduce_pipe #(.WIDTH(16), .FANIN(4)) dut2 (
    .CK(CK), .RN(RN), .A(a2), .MODE(mode[2]), .VI(vi[2]),
    .RI(ri[2]), .ZN0(zn[2]), .VO(vo[2]), .RO(ro[2]));
  nor_reduce_pipe #(.WIDTH(17), .FANIN(2)) dut3 (
    .CK(CK), .RN(RN), .A(a3), .MODE(mode[3]), .VI(vi[3]),
    .RI(ri[3]), .ZN0(zn[3]), .VO(vo[3]), .RO(ro[3]));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Flat bit-serial reference, deliberately not tree-shaped.
  function automatic logic model(input logic [31:0] a, input int w, input logic [2:0] m);
    logic r;
    r = (m[1:0] == 2'b01);
    for (int i = 0; i < w; i++) begin
      case (m[1:0])
        2'b01:   r = r & a[i];
        2'b10:   r = r ^ a[i];
        default: r = r | a[i];
      endcase
    end
    return r ^ m[2];
  endfunction

  function automatic logic [31:0] a_of(input int i);
    case (i)
      0:       return {22'd0, a0};
      1:       return {31'd0, a1};
      2:       return {16'd0, a2};
      default: return {15'd0, a3};
    endcase
  endfunction

  always @(negedge CK) begin
    exp_t e;
    cyc = cyc + 1;
    if (RN) begin
      for (int i = 0; i < 4; i++) begin
        if (vi[i] && ri[i]) begin
          e.z   = model(a_of(i), WS[i], mode[i]);
          e.cyc = cyc;
          q[i].push_back(e);
        end
        if (vo[i] && ro[i]) begin
          total = total + 1;
          assert (q[i].size() != 0) else begin
            bad = bad + 1;
            $error("FAIL extra_token dut%0d: token seen, expected none", i);
          end
          if (q[i].size() != 0) begin
            e = q[i].pop_front();
            total = total + 1;
            assert (zn[i] === e.z) else begin
              bad = bad + 1;
              $error("FAIL sb_zn0 dut%0d: got %b expected %b", i, zn[i], e.z);
            end
            if (lat_chk) begin
              total = total + 1;
              assert (cyc - e.cyc == LS[i]) else begin
                bad = bad + 1;
                $error("FAIL latency dut%0d: got %0d expected %0d", i, cyc - e.cyc, LS[i]);
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] sw_a  [5];
    logic [2:0] sw_m  [5];
    logic       sw_z  [5];
    logic [9:0] bp_a  [4];
    logic [2:0] bp_m  [4];
    logic       hist  [10];
    logic       zn_snap;
    int         sent;
    int         stall_left;
    logic       post;

    sw_a = '{10'h3FF, 10'h3FF, 10'h007, 10'h007, 10'h000};
    sw_m = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
    sw_z = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bp_a = '{10'h155, 10'h000, 10'h3FF, 10'h0F0};
    bp_m = '{3'b100, 3'b001, 3'b010, 3'b110};

    // reset held with a valid all-ones input presented
    RN = 1'b0;
    vi = 4'b0001;
    ro = 4'b1111;
    a0 = 10'h3FF; a1 = '0; a2 = '0; a3 = '0;
    for (int i = 0; i < 4; i++) mode[i] = 3'b100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_vo", vo[0], 1'b0);
      chk("rst_zn", zn[0], 1'b0);
      chk("rst_ri", ri[0], 1'b1);
    end
    RN = 1'b1;
    vi[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_vo", vo[0], 1'b0);
      chk("post_rst_zn", zn[0], 1'b0);
    end

    // NOR stream, latency 2
    lat_chk = 1'b1;
    mode[0] = 3'b100;
    vi[0] = 1'b1; a0 = 10'h000;
    tick(); chk("nor_lat_vo0", vo[0], 1'b0);
    a0 = 10'h001;
    tick(); chk("nor_vo_t0", vo[0], 1'b1); chk("nor_zn_t0", zn[0], 1'b1);
    a0 = 10'h200;
    tick(); chk("nor_zn_t1", zn[0], 1'b0);
    a0 = 10'h3FF;
    tick(); chk("nor_zn_t2", zn[0], 1'b0);
    vi[0] = 1'b0;
    tick(); chk("nor_vo_t3", vo[0], 1'b1); chk("nor_zn_t3", zn[0], 1'b0);
    tick(); chk("nor_vo_end", vo[0], 1'b0);

    // mode sweep including the reserved encoding
    for (int s = 0; s < 6; s++) begin
      if (s < 5) begin
        vi[0] = 1'b1; a0 = sw_a[s]; mode[0] = sw_m[s];
      end else begin
        vi[0] = 1'b0;
      end
      tick();
      if (s >= 1) begin
        chk("sweep_vo", vo[0], 1'b1);
        chk("sweep_zn", zn[0], sw_z[s-1]);
      end
    end
    tick(); tick(); tick();

    // alternating bubbles with random data and mode
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) chk("bubble_vo", vo[0], hist[c-2]);
      hist[c] = (c % 2 == 0) && (c < 8);
      vi[0] = hist[c];
      a0 = 10'($urandom);
      mode[0] = 3'($urandom_range(0, 7));
      tick();
    end
    tick(); tick();

    // reset pulse with two tokens in flight, held by a stall
    mode[0] = 3'b100;
    vi[0] = 1'b1; a0 = 10'h000;
    tick();
    a0 = 10'h001;
    tick();
    vi[0] = 1'b0; ro[0] = 1'b0;
    #1;
    chk("mid_vo_before", vo[0], 1'b1);
    RN = 1'b0;
    #2;
    chk("mid_vo_drop", vo[0], 1'b0);
    chk("mid_zn_clr", zn[0], 1'b0);
    chk("mid_ri", ri[0], 1'b1);
    RN = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    ro[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_no_token", vo[0], 1'b0);
    end

    // backpressure: 5-cycle stall beginning at the first VO
    lat_chk = 1'b0;
    sent = 0;
    stall_left = -1;
    post = 1'b0;
    zn_snap = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (stall_left < 0 && vo[0]) begin
        stall_left = 5;
        zn_snap = zn[0];
      end
      ro[0] = !(stall_left > 0);
      vi[0] = (sent < 4);
      if (sent < 4) begin
        a0 = bp_a[sent];
        mode[0] = bp_m[sent];
      end
      #1;
      if (stall_left > 0) begin
        chk("bp_ri_low", ri[0], 1'b0);
        chk("bp_vo_hold", vo[0], 1'b1);
        if (stall_left < 5) chk("bp_zn_hold", zn[0], zn_snap);
        stall_left = stall_left - 1;
        if (stall_left == 0) post = 1'b1;
      end else if (post) begin
        chk("bp_ri_rise", ri[0], 1'b1);
        post = 1'b0;
      end
      if (vi[0] && ri[0]) sent = sent + 1;
      tick();
    end
    chk("bp_sent", sent == 4, 1'b1);
    vi[0] = 1'b0; ro[0] = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("bp_no_loss", q[0].size() == 0, 1'b1);

    // parameter corners: fixed latency with RO high, then random RO
    lat_chk = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 1; i < 4; i++) begin
        vi[i] = 1'($urandom_range(0, 1));
        mode[i] = 3'($urandom_range(0, 7));
      end
      a1 = 1'($urandom); a2 = 16'($urandom); a3 = 17'($urandom);
      tick();
    end
    vi[3:1] = 3'b000;
    for (int c = 0; c < 8; c++) tick();
    lat_chk = 1'b0;
    for (int c = 0; c < 80; c++) begin
      for (int i = 1; i < 4; i++) begin
        vi[i] = 1'($urandom_range(0, 1));
        ro[i] = 1'($urandom_range(0, 1));
        mode[i] = 3'($urandom_range(0, 7));
      end
      a1 = 1'($urandom); a2 = 16'($urandom); a3 = 17'($urandom);
      tick();
    end
    vi[3:1] = 3'b000;
    ro[3:1] = 3'b111;
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < 4; i++) chk("final_drain", q[i].size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nor_reduce_pipe.md
# nor_reduce_pipe

Parametrised, pipelined wide-input reduction gate for the schematic macro library: the registered, handshaked successor to the fixed-width combinational NOR macros. It reduces a WIDTH-bit input vector to one bit with a runtime-selectable function (OR/AND/XOR, optionally inverted; default NOR). The tree of FANIN-input groups is registered at every level, so arbitrarily wide reductions close timing. A valid/ready handshake lets it sit between streaming blocks with backpressure.

## Interface
- WIDTH, 10: number of reduction inputs, 1..256.
- FANIN, 4: inputs per tree node per level, 2..8.
- LEVELS, derived, not overridable: smallest L ≥ 1 with FANIN^L ≥ WIDTH. WIDTH=10, FANIN=4 gives 2.

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  reset, asynchronous, active-low.
- A  in  WIDTH  input vector.
- MODE  in  3  function, sampled with A. [1:0]: 00 OR, 01 AND, 10 XOR, 11 reserved (treated as OR). [2]: invert result. Default use is 3'b100 (NOR).
- VI  in  1  A/MODE valid.
- RI  out  1  ready to accept. Combinational: RI = !VO | RO.
- ZN0  out  1  reduced result.
- VO  out  1  ZN0 valid.
- RO  in  1  downstream ready.

## Operation
- **Transfer rules.**
  - Input transfer occurs when VI & RI.
  - Output transfer occurs when VO & RO.
- **Pipeline structure.**
  - There are LEVELS register stages. Stage k holds ceil(WIDTH/FANIN^k) partial results, a valid bit, and the MODE value.
  - MODE travels with its data; changing MODE mid-stream affects only subsequent transfers.
- **Level k node.** Reduces up to FANIN consecutive bits of level k-1, lowest index first, using op = MODE[1:0].
  - A partial (last) group is padded with the identity: 0 for OR/XOR, 1 for AND.
  - Padding must not alter the result.
- **Inversion.** MODE[2] inversion is applied only at the final stage, so ZN0 = MODE[2] ^ reduce(A).
- **Stall.** Global stall when VO & !RO: no stage updates, ZN0 and VO hold, and RI = 0.
- **Advance.** Otherwise all stages advance by one.
  - Stage 1 valid is loaded with VI.
  - A bubble (VI=0) propagates as valid=0.
  - Data registers of invalid stages may update freely, but ZN0 must only change on a cycle that loads a valid or invalid token into the last stage.
- **Reset.** RN low clears all valid bits, ZN0, and the data and MODE registers to 0, immediately and asynchronously.
  - Outputs during reset: VO=0, ZN0=0, RI=1.
  - Asserting RN mid-operation discards every in-flight token. No token emerges after release until a new VI transfer.
- **Reset release.** The first rising CK after RN rises may accept data.
- **Degenerate WIDTH=1.** LEVELS=1 and ZN0 = MODE[2] ^ A[0], registered.

## Timing
- **Latency.** LEVELS cycles from an input transfer edge to VO=1 with its ZN0, assuming no stall. WIDTH=10, FANIN=4 gives 2 cycles.
- **Throughput.** One result per cycle with RO held high.
- **Ordering.** Results leave in acceptance order. No loss and no duplication under any RO pattern.
- **Combinational paths.**
  - RO→RI is the only combinational input-to-output path.
  - No path from A, MODE or VI to any output.
- **Stall timing.**
  - RO low with VO=1: RI falls in the same cycle.
  - RO rising: RI rises in the same cycle, and the pipeline advances on that edge.

## Test plan
- **Reset.** Hold RN=0 while driving VI=1 and A=all-ones; release; then VI=0.
  - Required: VO=0, ZN0=0 and RI=1 throughout.
  - Required: no output token appears.
- **NOR basic (WIDTH=10, FANIN=4, MODE=100, RO=1).** Stream A=0x000, 0x001, 0x200, 0x3FF on consecutive cycles.
  - Required: ZN0 = 1,0,0,0 with VO=1, starting 2 cycles after the first transfer.
- **Mode sweep with padding.** Use A=0x3FF with MODE=001 (AND), then MODE=101 (NAND), then A=0x007 with MODE=010 (XOR), then MODE=110 (XNOR).
  - Required: ZN0 = 1,0,1,0.
  - Required: MODE=011 on A=0x000 gives 0 (behaves as OR).
- **Backpressure.** Send 4 tokens back-to-back; hold RO=0 for 5 cycles after the first VO.
  - Required: RI=0 and ZN0/VO stable during the stall.
  - Required: after RO=1, all 4 results emerge in order with none lost.
- **Bubbles and reset mid-flight.**
  - Alternate VI=1/0: required VO alternates and results stay correct.
  - Pulse RN low for a fraction of a cycle while 2 tokens are in flight: required VO drops immediately and those tokens never emerge.
- **Parameter corners.** Test WIDTH=1, WIDTH=16/FANIN=4 (2 levels, exact fit) and WIDTH=17/FANIN=2 (5 levels), each with randomized A, MODE and RO.
  - Required: every ZN0 matches MODE[2] ^ reduce(A) at latency LEVELS.
